fifo_canal_virtual: RTL and testbench

//  Per-virtual-channel FIFO (VC0/VC1) of the transmission layer; buffers 6-bit words ahead of the

---
 rtl/fifo_canal_virtual_pkg.sv | 12 +
 rtl/fifo_canal_virtual_memoria.sv | 31 +++
 rtl/fifo_canal_virtual.sv | 86 ++++++++
 tb/tb_fifo_canal_virtual.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_canal_virtual_pkg.sv
// Shared constants for the virtual-channel FIFOs of the transmission layer.
// Default word/depth sizing and flag thresholds used by fifo_canal_virtual and memoria_fifo.
package fifo_canal_virtual_pkg;

   localparam int DATA_W_DEF    = 6;
   localparam int ADDR_W_DEF    = 2;
   localparam int UMBRAL_AF_DEF = 3;
   localparam int UMBRAL_AE_DEF = 1;

   typedef logic [DATA_W_DEF-1:0] palabra_t;

endpackage

// File: rtl/fifo_canal_virtual_memoria.sv
// Storage array for fifo_canal_virtual: one synchronous write port, one registered read port.
// Only the read register is reset; array contents survive reset.
module memoria_fifo
   import fifo_canal_virtual_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Same-address read and write (push+pop at full) returns the old head word.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L)   rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/fifo_canal_virtual.sv
// Per-virtual-channel FIFO ahead of the routing arbiter, with empty/full/almost flags and sticky error.
// Optional macro FIFO_CUENTA_EN adds the registered occupancy output `cuenta`.
module fifo_canal_virtual
   import fifo_canal_virtual_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int UMBRAL_AF = UMBRAL_AF_DEF,
   parameter int UMBRAL_AE = UMBRAL_AE_DEF
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic              push,
   input  logic [DATA_W-1:0] data_in,
   input  logic              pop,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic              empty,
   output logic              full,
   output logic              almost_empty,
   output logic              almost_full,
`ifdef FIFO_CUENTA_EN
   output logic [ADDR_W:0]   cuenta,
`endif
   output logic              error
);

   localparam logic [ADDR_W:0] UNO   = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W:0] TH_AF = UMBRAL_AF[ADDR_W:0];
   localparam logic [ADDR_W:0] TH_AE = UMBRAL_AE[ADDR_W:0];

   logic [ADDR_W:0] wr_ptr;
   logic [ADDR_W:0] rd_ptr;
   logic [ADDR_W:0] ocupacion;
   logic            push_ok;
   logic            pop_ok;

   // Extra pointer MSB distinguishes full from empty when the low bits match.
   assign empty        = (wr_ptr == rd_ptr);
   assign full         = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                         (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
   assign almost_empty = (ocupacion <= TH_AE);
   assign almost_full  = (ocupacion >= TH_AF);

   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

`ifdef FIFO_CUENTA_EN
   assign cuenta = ocupacion;
`endif

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         ocupacion <= '0;
         valid_out <= 1'b0;
         error     <= 1'b0;
      end else begin
         valid_out <= pop_ok;
         if (push_ok) wr_ptr <= wr_ptr + UNO;
         if (pop_ok)  rd_ptr <= rd_ptr + UNO;
         case ({push_ok, pop_ok})
            2'b10:   ocupacion <= ocupacion + UNO;
            2'b01:   ocupacion <= ocupacion - UNO;
            default: ocupacion <= ocupacion;
         endcase
         if ((push && !push_ok) || (pop && !pop_ok)) error <= 1'b1;
      end
   end

   memoria_fifo #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_memoria (
      .clk     (clk),
      .reset_L (reset_L),
      .wr_en   (push_ok),
      .wr_addr (wr_ptr[ADDR_W-1:0]),
      .wr_data (data_in),
      .rd_en   (pop_ok),
      .rd_addr (rd_ptr[ADDR_W-1:0]),
      .rd_data (data_out)
   );

endmodule

// File: tb/tb_fifo_canal_virtual.sv
// Directed self-checking bench for fifo_canal_virtual (default build or FIFO_CUENTA_EN).
module tb_fifo_canal_virtual;

   logic       clk;
   logic       reset_L;
   logic       push;
   logic [5:0] data_in;
   logic       pop;
   logic [5:0] data_out;
   logic       valid_out;
   logic       empty;
   logic       full;
   logic       almost_empty;
   logic       almost_full;
   logic       error;
`ifdef FIFO_CUENTA_EN
   logic [2:0] cuenta;
`endif

   int total;
   int bad;

   fifo_canal_virtual dut (
      .clk          (clk),
      .reset_L      (reset_L),
      .push         (push),
      .data_in      (data_in),
      .pop          (pop),
      .data_out     (data_out),
      .valid_out    (valid_out),
      .empty        (empty),
      .full         (full),
      .almost_empty (almost_empty),
      .almost_full  (almost_full),
`ifdef FIFO_CUENTA_EN
      .cuenta       (cuenta),
`endif
      .error        (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      push    = 1'b0;
      pop     = 1'b0;
      data_in = '0;
      reset_L = 1'b0;
      #2;
      reset_L = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      pop = 1'b1;
      cycle();
      pop = 1'b0;
      push = 1'b1; data_in = 6'h11; cycle();
      data_in = 6'h12; pop = 1'b1; cycle();
      push = 1'b0; pop = 1'b0;
      #2;
      reset_L = 1'b0;
      #1;
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
      total++; if (almost_empty !== 1'b1) begin bad++; $display("FAIL reset_almost_empty got=%b exp=1", almost_empty); end
      total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
      total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b exp=0", error); end
      total++; if (full !== 1'b0 || almost_full !== 1'b0) begin bad++; $display("FAIL reset_full_af got=%b%b exp=00", full, almost_full); end
      total++; if (data_out !== 6'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", data_out); end
      #2;
      reset_L = 1'b1;
      cycle();
      total++; if (empty !== 1'b1 || valid_out !== 1'b0) begin bad++; $display("FAIL reset_release got=%b%b exp=10", empty, valid_out); end
   endtask

   task automatic test_fill();
      logic [5:0] w [4];
      logic [3:0] exp_af;
      logic [3:0] exp_full;
      logic [3:0] exp_ae;
      w[0] = 6'h01; w[1] = 6'h22; w[2] = 6'h03; w[3] = 6'h24;
      exp_ae = 4'b0001; exp_af = 4'b1100; exp_full = 4'b1000;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         push = 1'b1; data_in = w[i];
         cycle();
         total++;
         if (empty !== 1'b0 || almost_empty !== exp_ae[i] || almost_full !== exp_af[i] || full !== exp_full[i]) begin
            bad++;
            $display("FAIL fill_flags_%0d got e=%b ae=%b af=%b f=%b exp e=0 ae=%b af=%b f=%b",
                     i, empty, almost_empty, almost_full, full, exp_ae[i], exp_af[i], exp_full[i]);
         end
      end
      push = 1'b0;
      for (int i = 0; i < 4; i++) begin
         pop = 1'b1;
         cycle();
         total++;
         if (valid_out !== 1'b1 || data_out !== w[i]) begin
            bad++;
            $display("FAIL fill_pop_%0d got v=%b d=%h exp v=1 d=%h", i, valid_out, data_out, w[i]);
         end
      end
      pop = 1'b0;
      cycle();
      total++; if (valid_out !== 1'b0 || data_out !== 6'h24) begin bad++; $display("FAIL fill_idle got v=%b d=%h exp v=0 d=24", valid_out, data_out); end
      total++; if (empty !== 1'b1 || error !== 1'b0) begin bad++; $display("FAIL fill_end got e=%b err=%b exp e=1 err=0", empty, error); end
   endtask

   task automatic test_overflow();
      logic [5:0] w [4];
      w[0] = 6'h0A; w[1] = 6'h2B; w[2] = 6'h0C; w[3] = 6'h3D;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         push = 1'b1; data_in = w[i]; cycle();
      end
      data_in = 6'h3F; cycle();
      push = 1'b0;
      total++; if (error !== 1'b1 || full !== 1'b1) begin bad++; $display("FAIL ovf_flags got err=%b f=%b exp err=1 f=1", error, full); end
      for (int i = 0; i < 4; i++) begin
         pop = 1'b1; cycle();
         total++;
         if (valid_out !== 1'b1 || data_out !== w[i]) begin
            bad++;
            $display("FAIL ovf_pop_%0d got v=%b d=%h exp v=1 d=%h", i, valid_out, data_out, w[i]);
         end
      end
      pop = 1'b0;
      total++; if (empty !== 1'b1 || error !== 1'b1) begin bad++; $display("FAIL ovf_end got e=%b err=%b exp e=1 err=1", empty, error); end
   endtask

   task automatic test_underflow();
      do_reset();
      pop = 1'b1; cycle();
      pop = 1'b0;
      total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL udf_valid got=%b exp=0", valid_out); end
      total++; if (error !== 1'b1 || empty !== 1'b1) begin bad++; $display("FAIL udf_flags got err=%b e=%b exp err=1 e=1", error, empty); end
   endtask

   task automatic test_simultaneous();
      logic [5:0] w [4];
      w[0] = 6'h15; w[1] = 6'h16; w[2] = 6'h17; w[3] = 6'h18;
      do_reset();
      push = 1'b1; data_in = 6'h11; cycle();
      data_in = 6'h12; cycle();
      data_in = 6'h15; pop = 1'b1; cycle();
      total++; if (valid_out !== 1'b1 || data_out !== 6'h11) begin bad++; $display("FAIL sim_mid_data got v=%b d=%h exp v=1 d=11", valid_out, data_out); end
      total++; if (almost_empty !== 1'b0 || almost_full !== 1'b0 || error !== 1'b0) begin bad++; $display("FAIL sim_mid_flags got ae=%b af=%b err=%b exp 000", almost_empty, almost_full, error); end
      pop = 1'b0;
      data_in = 6'h16; cycle();
      data_in = 6'h17; cycle();
      total++; if (full !== 1'b1) begin bad++; $display("FAIL sim_prefull got=%b exp=1", full); end
      data_in = 6'h18; pop = 1'b1; cycle();
      total++; if (valid_out !== 1'b1 || data_out !== 6'h12) begin bad++; $display("FAIL sim_full_data got v=%b d=%h exp v=1 d=12", valid_out, data_out); end
      total++; if (full !== 1'b1 || error !== 1'b0) begin bad++; $display("FAIL sim_full_flags got f=%b err=%b exp f=1 err=0", full, error); end
      push = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         total++;
         if (valid_out !== 1'b1 || data_out !== w[i]) begin
            bad++;
            $display("FAIL sim_drain_%0d got v=%b d=%h exp v=1 d=%h", i, valid_out, data_out, w[i]);
         end
      end
      push = 1'b1; data_in = 6'h19; cycle();
      total++; if (valid_out !== 1'b0 || error !== 1'b1) begin bad++; $display("FAIL sim_empty got v=%b err=%b exp v=0 err=1", valid_out, error); end
      total++; if (empty !== 1'b0 || almost_empty !== 1'b1) begin bad++; $display("FAIL sim_empty_occ got e=%b ae=%b exp e=0 ae=1", empty, almost_empty); end
      push = 1'b0; cycle();
      pop = 1'b0;
      total++; if (valid_out !== 1'b1 || data_out !== 6'h19 || empty !== 1'b1) begin bad++; $display("FAIL sim_last got v=%b d=%h e=%b exp v=1 d=19 e=1", valid_out, data_out, empty); end
   endtask

   task automatic test_wrap();
      logic [5:0] q [$];
      logic [5:0] d;
      logic [5:0] exp_d;
      int occ;
      int nerr;
      d = 6'h05; occ = 0; nerr = 0;
      do_reset();
      for (int c = 0; c < 18; c++) begin
         push = (c < 14);
         pop  = (c >= 4);
         data_in = d;
         cycle();
         exp_d = 6'h00;
         if (pop && occ > 0) begin exp_d = q.pop_front(); occ--; end
         if (push) begin q.push_back(d); occ++; d = d + 6'h01; end
         if (pop) begin
            total++;
            if (valid_out !== 1'b1 || data_out !== exp_d) begin
               bad++; nerr++;
               $display("FAIL wrap_data_c%0d got v=%b d=%h exp v=1 d=%h", c, valid_out, data_out, exp_d);
            end
         end
         total++;
         if (empty !== (occ == 0) || full !== (occ == 4) || almost_empty !== (occ <= 1) || almost_full !== (occ >= 3)) begin
            bad++;
            $display("FAIL wrap_flags_c%0d got e=%b f=%b ae=%b af=%b occ_exp=%0d", c, empty, full, almost_empty, almost_full, occ);
         end
`ifdef FIFO_CUENTA_EN
         total++;
         if (cuenta !== 3'(occ)) begin
            bad++;
            $display("FAIL wrap_cuenta_c%0d got=%0d exp=%0d", c, cuenta, occ);
         end
`endif
      end
      push = 1'b0; pop = 1'b0;
      total++; if (error !== 1'b0) begin bad++; $display("FAIL wrap_error got=%b exp=0", error); end
   endtask

   initial begin
      total = 0; bad = 0;
      push = 1'b0; pop = 1'b0; data_in = '0; reset_L = 1'b0;
      #12;
      reset_L = 1'b1;
      test_reset();
      test_fill();
      test_overflow();
      test_underflow();
      test_simultaneous();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
